pc_seq_ctrl: RTL

- Multi-cycle instruction sequencer for the NPC core. It fetches the instruction at the current PC from instruction memory, holds it while the execute unit runs, then drives the PC adder operands and the PC register write-enable.
- Sits between the PC register/adder pair, the IMEM port and the EXU. It is the only source of PC write-enable.
- Handles sequential flow (pc+4), branch/jump redirects and ebreak halt.

---
 rtl/pc_seq_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/pc_seq_ctrl.sv
// Multi-cycle fetch/execute sequencer: fetches at cur_pc, holds inst for the EXU, sole source of pc_wen.
// Min 3 cycles/inst; stalls on imem_ready/imem_rvalid/exu_done. Optional WAIT watchdog: FETCH_TIMEOUT_EN.
module pc_seq_ctrl #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] cur_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] inst,
    output logic            inst_valid,
    input  logic            exu_done,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_base,
    input  logic [XLEN-1:0] redirect_off,
    input  logic            halt_req,
    output logic [XLEN-1:0] pc_a,
    output logic [XLEN-1:0] pc_b,
    output logic            pc_wen,
    output logic            halted,
    output logic [31:0]     retire_cnt,
    output logic            timeout_err
);

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_EXEC, S_HALT} state_t;

    state_t state, state_nxt;
    logic   retire;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;

    // A response arriving on the limit cycle takes precedence over the timeout.
    assign tmo_hit = (state == S_WAIT) && !imem_rvalid && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state != S_WAIT)
                tmo_cnt <= '0;
            else if (!imem_rvalid)
                tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_hit)
                timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_FETCH;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        pc_wen    = 1'b0;
        halted    = 1'b0;
        retire    = 1'b0;
        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready)
                    state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid)
                    state_nxt = S_EXEC;
`ifdef FETCH_TIMEOUT_EN
                else if (tmo_hit)
                    state_nxt = S_HALT;
`endif
            end
            S_EXEC: begin
                if (exu_done) begin
                    retire = 1'b1;
                    // halt wins over redirect: the PC is left pointing at the ebreak
                    if (halt_req) begin
                        state_nxt = S_HALT;
                    end else begin
                        pc_wen    = 1'b1;
                        state_nxt = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    assign imem_addr = cur_pc;
    assign pc_a      = redirect ? redirect_base : cur_pc;
    assign pc_b      = redirect ? redirect_off  : XLEN'(4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst       <= '0;
            inst_valid <= 1'b0;
            retire_cnt <= '0;
        end else begin
            inst_valid <= 1'b0;
            if (state == S_WAIT && imem_rvalid) begin
                inst       <= imem_rdata;
                inst_valid <= 1'b1;
            end
            if (retire)
                retire_cnt <= retire_cnt + 32'd1;
        end
    end

endmodule
